spi_frame_scheduler: RTL and testbench
======================================

Name: spi_frame_scheduler

Overview:
- Sequences display frames onto the shared SPI link toward the Arduino display.
- Decides when a frame is sent, which page it carries, and snapshots calculator state so each frame is coherent.
- Streams frame bytes to a byte-level SPI shifter over a valid/ready handshake and owns chip-select.
- Sits between the keyboard/calc core (mem, size, ptr, answer, jump) and the byte shifter.

Parameters:
- DEPTH, 32, expression memory depth in bytes
- WIDTH, 8, memory word width; fixed at 8
- PAGE, 16, bytes per display page; DEPTH = 2*PAGE
- NEW_WIDTH, 44, answer width; must be ≤ 44
- GAP_TICKS, 200, minimum clock cycles with cs high between frames
- SETUP_TICKS, 4, cycles from cs low to first tx_valid
- REFRESH_TICKS, 1000000, cycles after a frame ends before an unforced refresh frame

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- jump  in  1  page-toggle level; rising edge toggles page
- edit  in  1  edit strobe from keyboard; rising edge marks display dirty
- answer  in  NEW_WIDTH  current result
- mem  in  DEPTH x WIDTH  expression memory (unpacked array)
- size_in  in  $clog2(DEPTH+1)  expression length
- ptr_in  in  $clog2(DEPTH+1)  cursor position
- tx_ready  in  1  byte shifter can accept a byte
- tx_busy  in  1  byte shifter still shifting
- tx_valid  out  1  tx_data valid
- tx_data  out  8  frame byte
- cs  out  1  SPI chip-select, active-low
- curr_page  out  1  page currently selected
- frame_active  out  1  high from LOAD through RELEASE
- frame_count  out  8  completed frames, wraps 255→0

Behaviour:
- Reset (reset=0, async): cs=1, tx_valid=0, tx_data=0, curr_page=0, frame_active=0, frame_count=0. All counters and pending flags cleared; state=IDLE. Edge-detect registers load 0.
- Reset during a frame aborts it immediately; cs rises asynchronously. No partial-frame recovery.
- Edges: jump and edit are registered once; an edge is cur & ~prev.
  - A jump edge toggles curr_page on the next cycle and sets pending.
  - An edit edge sets pending.
  - Multiple events coalesce into one pending bit.
- Refresh timer: counts in IDLE only; reset to 0 on leaving RELEASE. On reaching REFRESH_TICKS-1 it sets pending.
- Frame format, 25 bytes, MSB first within each byte:
  - byte0 = 8'hA5 (sync)
  - bytes1..16 = snapshot mem[page*PAGE + i], i = 0..15
  - byte17 = zero-extended size
  - byte18 = zero-extended ptr
  - bytes19..24 = 48-bit {zero pad, page, answer}, most-significant byte first
- FSM:
  - IDLE: cs=1. If pending, go to LOAD.
  - LOAD, 1 cycle: snapshot PAGE bytes of the selected page, size_in, ptr_in, answer, curr_page into shadow registers. Clear pending. cs←0. Then SETUP.
  - SETUP: wait SETUP_TICKS cycles, then SEND with byte index 0.
  - SEND: tx_valid=1, tx_data=shadow[index].
    - Transfer occurs on a cycle with tx_valid & tx_ready. tx_data must stay stable while tx_valid & ~tx_ready.
    - On transfer at index 24, deassert tx_valid and go to DRAIN; otherwise index+1 and tx_valid stays 1, so back-to-back transfers are allowed.
  - DRAIN: wait until tx_busy=0 and tx_ready=1, then RELEASE.
  - RELEASE, 1 cycle: cs←1, frame_count+1, frame_active←0, then GAP.
  - GAP: cs=1 for GAP_TICKS cycles, then IDLE.
- Events during LOAD..GAP set pending, so exactly one further frame follows after GAP. Such a frame carries the new page/data; the in-flight frame keeps its snapshot.
- Simultaneous edit and jump edges are one pending event; the page still toggles.
- The snapshot is taken in LOAD only. mem changes mid-frame are invisible until the next frame.
- Unused encodings of the state register fall to IDLE with cs=1.

Test Plan:
- Reset low then high, no stimulus → cs=1, tx_valid=0, curr_page=0, frame_count=0. The first frame starts after REFRESH_TICKS idle cycles.
- mem[i]=i+1, size=5, ptr=3, answer=44'h00A_BCDE_F012, tx_ready=1, one edit pulse → 25 bytes, the first of which are A5,01..10,05,03,00,0A,BC,DE,F0,12. Then cs=1 and frame_count=1.
- Jump edge during byte 10 of a page-0 frame:
  - current frame continues with mem[0..15] and page bit 0.
  - curr_page=1 next cycle.
  - a second frame starts exactly GAP_TICKS+1 cycles after RELEASE, carrying mem[16..31] and byte19=8'h01.
- tx_ready held low 7 cycles at byte 5 → tx_data and tx_valid constant throughout. No byte is skipped or duplicated, and the total stays 25.
- Three edits plus one jump inside one frame → exactly one follow-up frame. frame_count increases by 2 total.
- Reset asserted at byte 12 → cs=1 in the same cycle (async), tx_valid=0, curr_page=0. After release, no frame is sent until a new event or refresh.

Source files
------------

// File: rtl/spi_frame_scheduler.sv
// Snapshots calculator state and streams 25-byte display frames to a byte shifter; owns SPI chip-select.
// Latency: LOAD + SETUP_TICKS cycles to the first byte; tx_data holds while tx_valid & ~tx_ready.
module spi_frame_scheduler #(
  parameter int DEPTH         = 32,
  parameter int WIDTH         = 8,
  parameter int PAGE          = 16,
  parameter int NEW_WIDTH     = 44,
  parameter int GAP_TICKS     = 200,
  parameter int SETUP_TICKS   = 4,
  parameter int REFRESH_TICKS = 1000000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         jump,
  input  logic                         edit,
  input  logic [NEW_WIDTH-1:0]         answer,
  input  logic [WIDTH-1:0]             mem [DEPTH],
  input  logic [$clog2(DEPTH+1)-1:0]   size_in,
  input  logic [$clog2(DEPTH+1)-1:0]   ptr_in,
  input  logic                         tx_ready,
  input  logic                         tx_busy,
  output logic                         tx_valid,
  output logic [7:0]                   tx_data,
  output logic                         cs,
  output logic                         curr_page,
  output logic                         frame_active,
  output logic [7:0]                   frame_count
);

  localparam int SW   = $clog2(DEPTH + 1);
  localparam int TW   = $clog2(GAP_TICKS + SETUP_TICKS + 1);
  localparam int RW   = $clog2(REFRESH_TICKS + 1);
  localparam int LAST = PAGE + 8;
  localparam int BW   = $clog2(LAST + 1);
  localparam int PW   = $clog2(PAGE);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETUP, S_SEND, S_DRAIN, S_RELEASE, S_GAP
  } state_t;

  state_t             state, state_nxt;
  logic               jump_q, edit_q, pending;
  logic [RW-1:0]      refresh_cnt;
  logic [TW-1:0]      tick_cnt;
  logic [BW-1:0]      byte_idx;
  logic [WIDTH-1:0]   sh_mem [PAGE];
  logic [SW-1:0]      sh_size, sh_ptr;
  logic [NEW_WIDTH-1:0] sh_answer;
  logic               sh_page;
  logic [47:0]        tail;
  logic [2:0]         tail_sel;
  logic [7:0]         frame_byte;

  logic jump_edge, edit_edge, refresh_hit, any_event;
  logic setup_done, gap_done, xfer, last_byte;

  assign jump_edge   = jump & ~jump_q;
  assign edit_edge   = edit & ~edit_q;
  assign refresh_hit = (state == S_IDLE) && (refresh_cnt == RW'(REFRESH_TICKS - 1));
  assign any_event   = jump_edge | edit_edge | refresh_hit;
  assign setup_done  = tick_cnt == TW'(SETUP_TICKS - 1);
  assign gap_done    = tick_cnt == TW'(GAP_TICKS - 1);
  assign xfer        = tx_valid & tx_ready;
  assign last_byte   = byte_idx == BW'(LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // A request that arrives during the frame launches the next one straight out of GAP.
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:    state_nxt = pending ? S_LOAD : S_IDLE;
      S_LOAD:    state_nxt = S_SETUP;
      S_SETUP:   state_nxt = setup_done ? S_SEND : S_SETUP;
      S_SEND:    state_nxt = (xfer && last_byte) ? S_DRAIN : S_SEND;
      S_DRAIN:   state_nxt = (!tx_busy && tx_ready) ? S_RELEASE : S_DRAIN;
      S_RELEASE: state_nxt = S_GAP;
      S_GAP:     state_nxt = gap_done ? (pending ? S_LOAD : S_IDLE) : S_GAP;
      default:   state_nxt = S_IDLE;
    endcase
  end

  assign tail     = {{(47 - NEW_WIDTH){1'b0}}, sh_page, sh_answer};
  assign tail_sel = 3'(BW'(LAST) - byte_idx);

  always_comb begin
    frame_byte = 8'hA5;
    if (byte_idx == '0)                  frame_byte = 8'hA5;
    else if (byte_idx <= BW'(PAGE))      frame_byte = sh_mem[PW'(byte_idx - BW'(1))];
    else if (byte_idx == BW'(PAGE + 1))  frame_byte = 8'(sh_size);
    else if (byte_idx == BW'(PAGE + 2))  frame_byte = 8'(sh_ptr);
    else                                 frame_byte = tail[{tail_sel, 3'b000} +: 8];
  end

  always_comb begin
    cs           = 1'b1;
    frame_active = 1'b0;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    case (state)
      S_LOAD: frame_active = 1'b1;
      S_SETUP, S_DRAIN, S_RELEASE: begin
        cs           = 1'b0;
        frame_active = 1'b1;
      end
      S_SEND: begin
        cs           = 1'b0;
        frame_active = 1'b1;
        tx_valid     = 1'b1;
        tx_data      = frame_byte;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      jump_q      <= 1'b0;
      edit_q      <= 1'b0;
      curr_page   <= 1'b0;
      pending     <= 1'b0;
      refresh_cnt <= '0;
      tick_cnt    <= '0;
      byte_idx    <= '0;
      frame_count <= 8'h00;
      sh_size     <= '0;
      sh_ptr      <= '0;
      sh_answer   <= '0;
      sh_page     <= 1'b0;
      for (int i = 0; i < PAGE; i++) sh_mem[i] <= '0;
    end else begin
      jump_q <= jump;
      edit_q <= edit;
      if (jump_edge) curr_page <= ~curr_page;

      if (state == S_LOAD) pending <= any_event;
      else if (any_event)  pending <= 1'b1;

      if (state == S_RELEASE)                 refresh_cnt <= '0;
      else if (state == S_IDLE && !refresh_hit) refresh_cnt <= refresh_cnt + RW'(1);

      if (state == S_SETUP || state == S_GAP) tick_cnt <= tick_cnt + TW'(1);
      else                                    tick_cnt <= '0;

      if (state == S_LOAD)           byte_idx <= '0;
      else if (xfer && !last_byte)   byte_idx <= byte_idx + BW'(1);

      if (state == S_RELEASE) frame_count <= frame_count + 8'd1;

      // The whole frame is served from this snapshot so it stays coherent.
      if (state == S_LOAD) begin
        for (int i = 0; i < PAGE; i++) sh_mem[i] <= curr_page ? mem[PAGE + i] : mem[i];
        sh_size   <= size_in;
        sh_ptr    <= ptr_in;
        sh_answer <= answer;
        sh_page   <= curr_page;
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_scheduler.sv
// Directed bench for spi_frame_scheduler: frame content, flow control, coalescing, abort on reset.
module tb_spi_frame_scheduler;

  localparam int DEPTH   = 32;
  localparam int PAGE    = 16;
  localparam int NW      = 40;
  localparam int GAP     = 20;
  localparam int SETUP   = 4;
  localparam int REFRESH = 300;
  localparam logic [NW-1:0] ANS = 40'h0A_BCDE_F012;

  logic          clock;
  logic          reset;
  logic          jump, edit;
  logic [NW-1:0] answer;
  logic [7:0]    mem [DEPTH];
  logic [5:0]    size_in, ptr_in;
  logic          tx_ready, tx_busy;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          cs, curr_page, frame_active;
  logic [7:0]    frame_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] q[$];

  spi_frame_scheduler #(
    .DEPTH(DEPTH), .WIDTH(8), .PAGE(PAGE), .NEW_WIDTH(NW),
    .GAP_TICKS(GAP), .SETUP_TICKS(SETUP), .REFRESH_TICKS(REFRESH)
  ) dut (
    .clock(clock), .reset(reset), .jump(jump), .edit(edit), .answer(answer),
    .mem(mem), .size_in(size_in), .ptr_in(ptr_in), .tx_ready(tx_ready),
    .tx_busy(tx_busy), .tx_valid(tx_valid), .tx_data(tx_data), .cs(cs),
    .curr_page(curr_page), .frame_active(frame_active), .frame_count(frame_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Record each byte that will be accepted at the coming rising edge.
  always @(negedge clock) begin
    #4;
    if (tx_valid && tx_ready) q.push_back(tx_data);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_active(input logic v, input int budget, output int n);
    n = 0;
    while (frame_active !== v && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (frame_active !== v) n = -1;
  endtask

  task automatic wait_q(input int sz, input int budget, output int n);
    n = 0;
    while (q.size() < sz && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (q.size() < sz) n = -1;
  endtask

  task automatic pulse_edit();
    #1 edit = 1'b1;
    @(negedge clock);
    #1 edit = 1'b0;
  endtask

  // mem[k] = k+1, size 5, ptr 3, tail {7'b0, page, ANS}
  function automatic logic [7:0] exp_byte(input int i, input logic pg);
    logic [47:0] t;
    t = {7'b0, pg, ANS};
    if (i == 0)  return 8'hA5;
    if (i <= 16) return 8'(int'(pg) * 16 + i);
    if (i == 17) return 8'd5;
    if (i == 18) return 8'd3;
    return t[8*(24-i) +: 8];
  endfunction

  task automatic chk_frame(input string tag, input int base, input logic pg);
    for (int i = 0; i < 25; i++)
      if (base + i < q.size()) chk($sformatf("%s_b%0d", tag, i), q[base+i], exp_byte(i, pg));
  endtask

  int n, fc0;
  logic seen;

  initial begin
    reset = 1'b0; jump = 1'b0; edit = 1'b0; tx_ready = 1'b1; tx_busy = 1'b0;
    size_in = 6'd5; ptr_in = 6'd3; answer = ANS;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i + 1);

    repeat (3) @(negedge clock);
    chk("rst_cs", cs, 1);
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_page", curr_page, 0);
    chk("rst_active", frame_active, 0);
    chk("rst_count", frame_count, 0);
    #1 reset = 1'b1;

    // Unforced refresh: LOAD appears on the REFRESH+1-th cycle after release.
    wait_active(1'b1, REFRESH + 50, n);
    chk("refresh_start", n, REFRESH + 1);
    wait_active(1'b0, 100, n);
    chk("refresh_end_to", n >= 0, 1);
    chk("refresh_len", q.size(), 25);
    chk("refresh_count", frame_count, 1);

    // Edit-triggered frame with hand-computed bytes.
    repeat (GAP + 5) @(negedge clock);
    q.delete();
    pulse_edit();
    wait_active(1'b1, 20, n);
    chk("edit_start_to", n >= 0, 1);
    wait_active(1'b0, 100, n);
    chk("edit_end_to", n >= 0, 1);
    chk("edit_len", q.size(), 25);
    chk_frame("edit", 0, 1'b0);
    if (q.size() == 25) begin
      chk("edit_sync", q[0], 8'hA5);
      chk("edit_size", q[17], 8'h05);
      chk("edit_ans0", q[19], 8'h00);
      chk("edit_ans1", q[20], 8'h0A);
      chk("edit_ans5", q[24], 8'h12);
    end
    chk("edit_cs", cs, 1);
    chk("edit_count", frame_count, 2);

    // Jump while byte 10 goes out: frame keeps page 0; follow-up carries page 1.
    repeat (GAP + 5) @(negedge clock);
    q.delete();
    pulse_edit();
    wait_q(10, 100, n);
    chk("jump_q10_to", n >= 0, 1);
    #1 jump = 1'b1;
    @(negedge clock);
    chk("jump_page", curr_page, 1);
    wait_active(1'b0, 100, n);
    chk("jump_f1_end_to", n >= 0, 1);
    chk("jump_f1_len", q.size(), 25);
    chk_frame("jump_f1", 0, 1'b0);
    // RELEASE at t, LOAD at t+GAP+1: GAP cycles with frame_active low in between.
    wait_active(1'b1, GAP + 10, n);
    chk("jump_gap", n, GAP);
    wait_active(1'b0, 100, n);
    chk("jump_f2_end_to", n >= 0, 1);
    chk("jump_f2_len", q.size(), 50);
    chk_frame("jump_f2", 25, 1'b1);
    if (q.size() == 50) chk("jump_f2_pagebyte", q[44], 8'h01);
    chk("jump_count", frame_count, 4);
    #1 jump = 1'b1;

    // Backpressure: tx_ready low for 7 cycles while byte 5 is offered.
    repeat (GAP + 5) @(negedge clock);
    q.delete();
    pulse_edit();
    wait_q(5, 100, n);
    chk("bp_q5_to", n >= 0, 1);
    #1 tx_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      chk($sformatf("bp_valid_%0d", k), tx_valid, 1);
      chk($sformatf("bp_data_%0d", k), tx_data, 8'h15);
    end
    #1 tx_ready = 1'b1;
    wait_active(1'b0, 100, n);
    chk("bp_end_to", n >= 0, 1);
    chk("bp_len", q.size(), 25);
    chk_frame("bp", 0, 1'b1);

    // Three edits and a jump inside one frame coalesce into one follow-up frame.
    repeat (GAP + 5) @(negedge clock);
    q.delete();
    fc0 = int'(frame_count);
    #1 jump = 1'b0;
    pulse_edit();
    wait_q(3, 100, n);
    chk("coal_q3_to", n >= 0, 1);
    for (int k = 0; k < 3; k++) begin
      pulse_edit();
      @(negedge clock);
    end
    #1 jump = 1'b1;
    wait_active(1'b0, 100, n);
    chk("coal_f1_to", n >= 0, 1);
    wait_active(1'b1, GAP + 10, n);
    chk("coal_f2_start_to", n >= 0, 1);
    wait_active(1'b0, 100, n);
    chk("coal_f2_end_to", n >= 0, 1);
    seen = 1'b0;
    repeat (80) begin
      @(negedge clock);
      if (frame_active) seen = 1'b1;
    end
    chk("coal_no_third", seen, 0);
    chk("coal_count", frame_count, 8'(fc0 + 2));
    chk("coal_page", curr_page, 0);
    chk("coal_len", q.size(), 50);

    // Reset in the middle of a page-1 frame aborts it at once.
    #1 jump = 1'b0;
    @(negedge clock);
    q.delete();
    #1 jump = 1'b1;
    @(negedge clock);
    #1 jump = 1'b0;
    wait_q(12, 100, n);
    chk("abort_q12_to", n >= 0, 1);
    chk("abort_page_pre", curr_page, 1);
    #1 reset = 1'b0;
    #1;
    chk("abort_cs", cs, 1);
    chk("abort_valid", tx_valid, 0);
    chk("abort_page", curr_page, 0);
    chk("abort_active", frame_active, 0);
    chk("abort_count", frame_count, 0);
    repeat (2) @(negedge clock);
    #1 reset = 1'b1;
    seen = 1'b0;
    repeat (100) begin
      @(negedge clock);
      if (frame_active || !cs) seen = 1'b1;
    end
    chk("abort_quiet", seen, 0);
    chk("abort_len", q.size(), 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
